// File: rtl/head_meta_emit.sv
// Head/meta slice buffering with per-packet admission control and an output
// sequencer that emits an optional meta word followed by the packet's head words.
module head_meta_emit #(
    parameter int unsigned HEAD_WIDTH     = 512,
    parameter int unsigned META_WIDTH     = 512,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned HFIFO_DEPTH    = 16,
    parameter int unsigned MFIFO_DEPTH    = 4,
    parameter int unsigned MAX_PKT_SLICES = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
    output logic [HEAD_WIDTH-1:0]           o_data,
    output logic                            o_valid,
    output logic                            o_isMeta,
    output logic                            o_sop,
    output logic                            o_eop,
    input  logic                            i_ready,
    output logic [15:0]                     o_dropCnt
);

    localparam int unsigned HAW      = $clog2(HFIFO_DEPTH);
    localparam int unsigned MAW      = $clog2(MFIFO_DEPTH);
    localparam int unsigned FREE_W   = HAW + 2;
    localparam int unsigned BIT_START = 3;
    localparam int unsigned BIT_TAIL  = 2;
    localparam int unsigned BIT_VALID = 1;
    localparam int unsigned BIT_SHIFT = 0;

    generate
        if (META_WIDTH != HEAD_WIDTH || MAX_PKT_SLICES > HFIFO_DEPTH || TAG_WIDTH < 4) begin : g_bad_param
            $error("head_meta_emit: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_META,
        ST_HEAD
    } state_t;

    // Tag decode
    logic head_start, head_tail, head_valid, meta_shift_in;
    logic unused_tags;

    assign head_start    = i_head[HEAD_WIDTH + BIT_START];
    assign head_tail     = i_head[HEAD_WIDTH + BIT_TAIL];
    assign head_valid    = i_head[HEAD_WIDTH + BIT_VALID];
    assign meta_shift_in = i_meta[META_WIDTH + BIT_SHIFT];
    assign unused_tags   = ^{i_head[HEAD_WIDTH + BIT_SHIFT],
                             i_meta[META_WIDTH + BIT_START],
                             i_meta[META_WIDTH + BIT_TAIL],
                             i_meta[META_WIDTH + BIT_VALID]};

    // Head FIFO: {tail, data}
    logic [HEAD_WIDTH:0] hmem [HFIFO_DEPTH];
    logic [HAW:0]        hwr_ptr, hrd_ptr, h_count;
    logic                h_empty, h_full, h_rd, h_wr, h_wr_want;
    logic [HEAD_WIDTH:0] h_head;

    assign h_empty = (hwr_ptr == hrd_ptr);
    assign h_full  = (hwr_ptr[HAW] != hrd_ptr[HAW]) && (hwr_ptr[HAW-1:0] == hrd_ptr[HAW-1:0]);
    assign h_count = hwr_ptr - hrd_ptr;
    assign h_head  = hmem[hrd_ptr[HAW-1:0]];
    assign h_wr    = h_wr_want && (!h_full || h_rd);

    // Meta FIFO: {shift, data}
    logic [META_WIDTH:0] mmem [MFIFO_DEPTH];
    logic [MAW:0]        mwr_ptr, mrd_ptr;
    logic                m_empty, m_full, m_rd, m_wr;
    logic [META_WIDTH:0] m_head;

    assign m_empty = (mwr_ptr == mrd_ptr);
    assign m_full  = (mwr_ptr[MAW] != mrd_ptr[MAW]) && (mwr_ptr[MAW-1:0] == mrd_ptr[MAW-1:0]);
    assign m_head  = mmem[mrd_ptr[MAW-1:0]];

    always_ff @(posedge i_clk) begin
        if (h_wr) begin
            hmem[hwr_ptr[HAW-1:0]] <= {head_tail, i_head[HEAD_WIDTH-1:0]};
        end
        if (m_wr) begin
            mmem[mwr_ptr[MAW-1:0]] <= {meta_shift_in, i_meta[META_WIDTH-1:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hwr_ptr <= '0;
            hrd_ptr <= '0;
            mwr_ptr <= '0;
            mrd_ptr <= '0;
        end else begin
            if (h_wr) hwr_ptr <= hwr_ptr + 1'b1;
            if (h_rd) hrd_ptr <= hrd_ptr + 1'b1;
            if (m_wr) mwr_ptr <= mwr_ptr + 1'b1;
            if (m_rd) mrd_ptr <= mrd_ptr + 1'b1;
        end
    end

    // Admission: free space counts the entry being popped this cycle
    logic [FREE_W-1:0] h_free;
    logic              admit, reject;
    logic              in_pkt_q, in_pkt_d, drop_q, drop_d;

    assign h_free = FREE_W'(HFIFO_DEPTH) - FREE_W'(h_count) + FREE_W'(h_rd);
    assign admit  = head_start && (h_free >= FREE_W'(MAX_PKT_SLICES)) && (!m_full || m_rd);

    always_comb begin
        h_wr_want = 1'b0;
        m_wr      = 1'b0;
        reject    = 1'b0;
        in_pkt_d  = in_pkt_q;
        drop_d    = drop_q;
        if (head_start) begin
            if (admit) begin
                m_wr      = 1'b1;
                h_wr_want = head_valid;
                in_pkt_d  = !head_tail;
                drop_d    = 1'b0;
            end else begin
                reject    = 1'b1;
                in_pkt_d  = 1'b0;
                drop_d    = !head_tail;
            end
        end else if (head_valid) begin
            if (in_pkt_q) begin
                h_wr_want = 1'b1;
                if (head_tail) in_pkt_d = 1'b0;
            end else if (drop_q && head_tail) begin
                drop_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_pkt_q  <= 1'b0;
            drop_q    <= 1'b0;
            o_dropCnt <= '0;
        end else begin
            in_pkt_q <= in_pkt_d;
            drop_q   <= drop_d;
            if (reject && (o_dropCnt != 16'hFFFF)) begin
                o_dropCnt <= o_dropCnt + 16'd1;
            end
        end
    end

    // Output sequencer state register
    state_t state_q, state_d;
    logic   first_q, first_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Outputs decode from state and FIFO heads only; no input-to-output path
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        h_rd     = 1'b0;
        m_rd     = 1'b0;
        o_valid  = 1'b0;
        o_isMeta = 1'b0;
        o_sop    = 1'b0;
        o_eop    = 1'b0;
        o_data   = '0;
        case (state_q)
            ST_IDLE: begin
                if (!m_empty && !h_empty) begin
                    if (m_head[META_WIDTH]) begin
                        m_rd    = 1'b1;
                        first_d = 1'b1;
                        state_d = ST_HEAD;
                    end else begin
                        state_d = ST_META;
                    end
                end
            end
            ST_META: begin
                o_valid  = 1'b1;
                o_isMeta = 1'b1;
                o_sop    = 1'b1;
                o_data   = HEAD_WIDTH'(m_head[META_WIDTH-1:0]);
                if (i_ready) begin
                    m_rd    = 1'b1;
                    first_d = 1'b0;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (!h_empty) begin
                    o_valid = 1'b1;
                    o_data  = h_head[HEAD_WIDTH-1:0];
                    o_eop   = h_head[HEAD_WIDTH];
                    o_sop   = first_q;
                    if (i_ready) begin
                        h_rd    = 1'b1;
                        first_d = 1'b0;
                        if (h_head[HEAD_WIDTH]) state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_head_meta_emit.sv
// Scoreboard bench for head_meta_emit: expected words queued as packets are driven.
module tb_head_meta_emit;

    localparam int unsigned HW = 32;
    localparam int unsigned TW = 4;

    logic          i_clk;
    logic          i_rst;
    logic [HW+TW-1:0] i_head;
    logic [HW+TW-1:0] i_meta;
    logic [HW-1:0] o_data;
    logic          o_valid, o_isMeta, o_sop, o_eop;
    logic          i_ready;
    logic [15:0]   o_dropCnt;

    head_meta_emit #(
        .HEAD_WIDTH(HW), .META_WIDTH(HW), .TAG_WIDTH(TW),
        .HFIFO_DEPTH(16), .MFIFO_DEPTH(4), .MAX_PKT_SLICES(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_head(i_head), .i_meta(i_meta),
        .o_data(o_data), .o_valid(o_valid), .o_isMeta(o_isMeta),
        .o_sop(o_sop), .o_eop(o_eop), .i_ready(i_ready), .o_dropCnt(o_dropCnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [HW-1:0] data;
        logic          is_meta;
        logic          sop;
        logic          eop;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    run_len  = 0;
    int    max_run  = 0;
    logic  held     = 1'b0;
    word_t held_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Observe outputs mid-cycle; i_ready here is what the next edge samples
    task automatic monitor();
        word_t cur;
        word_t e;
        if (i_rst) begin
            held    = 1'b0;
            run_len = 0;
            return;
        end
        cur = '{data: o_data, is_meta: o_isMeta, sop: o_sop, eop: o_eop};
        if (held && o_valid) check("hold_stable", 64'(cur), 64'(held_w));
        run_len = o_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("word", 64'(cur), 64'(e));
            end
        end
        held   = o_valid && !i_ready;
        held_w = cur;
    endtask

    task automatic tick();
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pkt(input int pid, input int n, input bit shift, input bit admit);
        if (admit) begin
            if (!shift) exp_q.push_back('{data: 32'hA000_0000 + 32'(pid), is_meta: 1'b1, sop: 1'b1, eop: 1'b0});
            for (int i = 0; i < n; i++)
                exp_q.push_back('{data: 32'(pid * 256 + i), is_meta: 1'b0,
                                  sop: shift && (i == 0), eop: (i == n - 1)});
        end
        for (int i = 0; i < n; i++) begin
            i_head = {(i == 0), (i == n - 1), 1'b1, 1'b0, 32'(pid * 256 + i)};
            i_meta = (i == 0) ? {1'b1, 1'b0, 1'b1, shift, 32'hA000_0000 + 32'(pid)} : '0;
            tick();
        end
        i_head = '0;
        i_meta = '0;
    endtask

    task automatic send_orphans();
        for (int i = 0; i < 3; i++) begin
            i_head = {1'b0, (i == 2), 1'b1, 1'b0, 32'h0BAD_0000 + 32'(i)};
            i_meta = (i == 0) ? {1'b1, 1'b0, 1'b1, 1'b0, 32'h0BAD_FFFF} : '0;
            tick();
        end
        i_head = '0;
        i_meta = '0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
        repeat (3) tick();
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_ready = 1'b0;
        i_head  = '0;
        i_meta  = '0;
        @(posedge i_clk);
        #1;
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ismeta", 64'(o_isMeta), 64'd0);
        check("rst_sop", 64'(o_sop), 64'd0);
        check("rst_eop", 64'(o_eop), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_drop", 64'(o_dropCnt), 64'd0);
        i_rst = 1'b0;
        tick();

        // Meta then three head words, back to back
        i_ready = 1'b1;
        max_run = 0;
        send_pkt(1, 3, 1'b0, 1'b1);
        drain("meta3");
        check("meta3_run", 64'(max_run), 64'd4);

        // Shifted packet: meta suppressed, sop on first head word
        max_run = 0;
        send_pkt(2, 3, 1'b1, 1'b1);
        drain("shift3");
        check("shift3_run", 64'(max_run), 64'd3);
        check("shift3_drop", 64'(o_dropCnt), 64'd0);

        // Two packets while stalled 20 cycles
        i_ready = 1'b0;
        send_pkt(3, 4, 1'b0, 1'b1);
        send_pkt(4, 4, 1'b0, 1'b1);
        repeat (12) tick();
        check("stall_q", 64'(exp_q.size()), 64'd10);
        i_ready = 1'b1;
        drain("stall");
        check("stall_drop", 64'(o_dropCnt), 64'd0);

        // Admission limit: third 8-slice packet rejected
        i_ready = 1'b0;
        send_pkt(5, 8, 1'b0, 1'b1);
        send_pkt(6, 8, 1'b0, 1'b1);
        send_pkt(7, 8, 1'b0, 1'b0);
        check("adm_drop", 64'(o_dropCnt), 64'd1);
        repeat (5) tick();
        i_ready = 1'b1;
        drain("adm");
        check("adm_drop_after", 64'(o_dropCnt), 64'd1);

        // Slices without START, plus a lone meta START, produce nothing
        send_orphans();
        repeat (10) tick();
        check("orphan_drop", 64'(o_dropCnt), 64'd1);
        check("orphan_q", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of HEAD with two words still buffered
        i_ready = 1'b0;
        send_pkt(8, 3, 1'b0, 1'b1);
        repeat (3) tick();
        i_ready = 1'b1;
        tick();
        tick();
        i_ready = 1'b0;
        check("mid_q", 64'(exp_q.size()), 64'd2);
        check("mid_valid", 64'(o_valid), 64'd1);
        exp_q.delete();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("post_rst_valid", 64'(o_valid), 64'd0);
        check("post_rst_drop", 64'(o_dropCnt), 64'd0);
        tick();
        check("post_rst_idle", 64'(o_valid), 64'd0);
        i_ready = 1'b1;
        send_pkt(9, 1, 1'b0, 1'b1);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
